// File: rtl/cached_mem_sys.sv
// Direct-mapped write-back I/D cache pair sharing one miss controller that
// arbitrates both caches onto a single line-wide req/rdy memory port.
module cached_mem_sys #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned SETS   = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_fetch,
    input  logic [ADDR_W-1:0]                 i_addr,
    output logic [DATA_W-1:0]                 instr,
    input  logic                              re,
    input  logic                              we,
    input  logic [ADDR_W-1:0]                 d_addr,
    input  logic [DATA_W-1:0]                 wrt_data,
    output logic [DATA_W-1:0]                 rd_data,
    output logic                              stall,
    output logic [ADDR_W-$clog2(WORDS)-1:0]   m_addr,
    output logic                              m_re,
    output logic                              m_we,
    output logic [WORDS*DATA_W-1:0]           m_wdata,
    input  logic [WORDS*DATA_W-1:0]           m_rdata,
    input  logic                              m_rdy,
    output logic [15:0]                       i_miss_cnt,
    output logic [15:0]                       d_miss_cnt
);
    localparam int unsigned LINE_W = WORDS * DATA_W;
    localparam int unsigned OFF_W  = $clog2(WORDS);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {IDLE, WB, FILL_D, FILL_I} state_t;
    state_t state;

    logic [LINE_W-1:0] d_line [SETS];
    logic [TAG_W-1:0]  d_tag_arr [SETS];
    logic [SETS-1:0]   d_valid;
    logic [SETS-1:0]   d_dirty;
    logic [LINE_W-1:0] i_line [SETS];
    logic [TAG_W-1:0]  i_tag_arr [SETS];
    logic [SETS-1:0]   i_valid;

    logic [TAG_W-1:0] d_tag, i_tag;
    logic [IDX_W-1:0] d_idx, i_idx;
    logic [OFF_W-1:0] d_off, i_off;

    assign d_tag = d_addr[ADDR_W-1 -: TAG_W];
    assign d_idx = d_addr[OFF_W +: IDX_W];
    assign d_off = d_addr[OFF_W-1:0];
    assign i_tag = i_addr[ADDR_W-1 -: TAG_W];
    assign i_idx = i_addr[OFF_W +: IDX_W];
    assign i_off = i_addr[OFF_W-1:0];

    logic d_hit, i_hit, d_miss, i_miss, d_wr, d_fill, i_fill, victim_dirty;

    assign d_hit        = d_valid[d_idx] && (d_tag_arr[d_idx] == d_tag);
    assign i_hit        = i_valid[i_idx] && (i_tag_arr[i_idx] == i_tag);
    assign d_miss       = (re || we) && !d_hit;
    assign i_miss       = i_fetch && !i_hit;
    assign victim_dirty = d_valid[d_idx] && d_dirty[d_idx];
    assign d_wr         = (state == IDLE) && we && d_hit;
    assign d_fill       = (state == FILL_D) && m_rdy;
    assign i_fill       = (state == FILL_I) && m_rdy;

    assign stall   = (state != IDLE) || d_miss || i_miss;
    assign rd_data = d_line[d_idx][d_off*DATA_W +: DATA_W];
    assign instr   = i_line[i_idx][i_off*DATA_W +: DATA_W];
    assign m_re    = (state == FILL_D) || (state == FILL_I);
    assign m_we    = (state == WB);

    // Miss controller: D miss wins in IDLE; dirty victims are written back first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            d_valid    <= '0;
            d_dirty    <= '0;
            i_valid    <= '0;
            i_miss_cnt <= '0;
            d_miss_cnt <= '0;
            m_addr     <= '0;
            m_wdata    <= '0;
        end else begin
            if (d_wr) d_dirty[d_idx] <= 1'b1;
            case (state)
                IDLE: begin
                    if (d_miss) begin
                        if (victim_dirty) begin
                            state   <= WB;
                            m_addr  <= {d_tag_arr[d_idx], d_idx};
                            m_wdata <= d_line[d_idx];
                        end else begin
                            state  <= FILL_D;
                            m_addr <= {d_tag, d_idx};
                        end
                        if (d_miss_cnt != 16'hFFFF) d_miss_cnt <= d_miss_cnt + 16'd1;
                    end else if (i_miss) begin
                        state  <= FILL_I;
                        m_addr <= {i_tag, i_idx};
                        if (i_miss_cnt != 16'hFFFF) i_miss_cnt <= i_miss_cnt + 16'd1;
                    end
                end
                WB: begin
                    if (m_rdy) begin
                        d_dirty[d_idx] <= 1'b0;
                        state          <= FILL_D;
                        m_addr         <= {d_tag, d_idx};
                    end
                end
                FILL_D: begin
                    if (m_rdy) begin
                        d_valid[d_idx] <= 1'b1;
                        d_dirty[d_idx] <= 1'b0;
                        state          <= IDLE;
                    end
                end
                FILL_I: begin
                    if (m_rdy) begin
                        i_valid[i_idx] <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line and tag arrays; reset blocks any in-flight fill or store.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (d_fill) begin
                d_line[d_idx]    <= m_rdata;
                d_tag_arr[d_idx] <= d_tag;
            end else if (d_wr) begin
                d_line[d_idx][d_off*DATA_W +: DATA_W] <= wrt_data;
            end
            if (i_fill) begin
                i_line[i_idx]    <= m_rdata;
                i_tag_arr[i_idx] <= i_tag;
            end
        end
    end
endmodule

// File: tb/tb_cached_mem_sys.sv
// Directed bench for cached_mem_sys: hits, clean/dirty misses, arbitration,
// reset abort and miss-counter saturation, with a tiny in-bench memory responder.
module tb_cached_mem_sys;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_fetch;
    logic [15:0] i_addr;
    logic [15:0] instr;
    logic        re;
    logic        we;
    logic [15:0] d_addr;
    logic [15:0] wrt_data;
    logic [15:0] rd_data;
    logic        stall;
    logic [13:0] m_addr;
    logic        m_re;
    logic        m_we;
    logic [63:0] m_wdata;
    logic [63:0] m_rdata;
    logic        m_rdy;
    logic [15:0] i_miss_cnt;
    logic [15:0] d_miss_cnt;

    int checks = 0;
    int failures = 0;

    logic [13:0] fill_log [$];
    logic [13:0] wb_addr_seen;
    logic [63:0] wb_data_seen;
    logic        both_seen;
    logic        we_seen;
    int          st;

    cached_mem_sys dut (
        .clk(clk), .rst(rst),
        .i_fetch(i_fetch), .i_addr(i_addr), .instr(instr),
        .re(re), .we(we), .d_addr(d_addr), .wrt_data(wrt_data), .rd_data(rd_data),
        .stall(stall),
        .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_rdy(m_rdy),
        .i_miss_cnt(i_miss_cnt), .d_miss_cnt(d_miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; re = 1'b0; we = 1'b0; i_fetch = 1'b0; m_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Memory responder: each WB/FILL phase answers with m_rdy in its lat-th cycle.
    task automatic service(input int lat, input logic [63:0] fill, output int stalls);
        int cnt;
        cnt = 0;
        stalls = 0;
        while (stall === 1'b1 && stalls < 200) begin
            if (m_re && m_we) both_seen = 1'b1;
            if (m_we) begin
                wb_addr_seen = m_addr;
                wb_data_seen = m_wdata;
                we_seen      = 1'b1;
            end
            if (m_re && cnt == 0) fill_log.push_back(m_addr);
            if (m_re || m_we) begin
                cnt++;
                if (cnt == lat) begin
                    m_rdy   = 1'b1;
                    m_rdata = fill;
                end
            end
            stalls++;
            @(negedge clk);
            if (m_rdy) cnt = 0;
            m_rdy = 1'b0;
            #1;
        end
        chk("svc_no_timeout", 64'(stalls < 200), 64'd1);
    endtask

    initial begin
        i_addr = '0; d_addr = '0; wrt_data = '0; m_rdata = '0;
        both_seen = 1'b0; we_seen = 1'b0; wb_addr_seen = '0; wb_data_seen = '0;
        do_reset();
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_m_re", 64'(m_re), 64'd0);
        chk("rst_m_we", 64'(m_we), 64'd0);
        chk("rst_m_addr", 64'(m_addr), 64'd0);
        chk("rst_m_wdata", m_wdata, 64'd0);
        chk("rst_d_cnt", 64'(d_miss_cnt), 64'd0);
        chk("rst_i_cnt", 64'(i_miss_cnt), 64'd0);

        // Clean read miss, memory latency 3
        re = 1'b1; d_addr = 16'h0010; #1;
        chk("miss_stall_c0", 64'(stall), 64'd1);
        service(3, {16'h3333, 16'h2222, 16'h1111, 16'hBEEF}, st);
        chk("miss_stalls", 64'(st), 64'd4);
        chk("miss_rd_data", 64'(rd_data), 64'hBEEF);
        chk("miss_fill_addr", 64'(fill_log[0]), 64'h0004);
        chk("miss_d_cnt", 64'(d_miss_cnt), 64'd1);
        chk("miss_m_re_drop", 64'(m_re), 64'd0);

        // Write hit then read back, no memory traffic
        re = 1'b0; we = 1'b1; d_addr = 16'h0011; wrt_data = 16'h1234; #1;
        chk("wr_hit_stall", 64'(stall), 64'd0);
        @(negedge clk); we = 1'b0; re = 1'b1; #1;
        chk("rd_hit_stall", 64'(stall), 64'd0);
        chk("rd_hit_data", 64'(rd_data), 64'h1234);
        re = 1'b1; we = 1'b1; d_addr = 16'h0012; wrt_data = 16'h5678; #1;
        chk("rw_pre_write", 64'(rd_data), 64'h2222);
        @(negedge clk); we = 1'b0; #1;
        chk("rw_post_write", 64'(rd_data), 64'h5678);
        chk("no_m_we", 64'(m_we | we_seen), 64'd0);

        // Dirty victim: write-back then fill
        fill_log.delete();
        re = 1'b1; d_addr = 16'h4010; #1;
        chk("wb_stall_c0", 64'(stall), 64'd1);
        service(2, {16'h0, 16'h0, 16'h0, 16'hCAFE}, st);
        chk("wb_stalls", 64'(st), 64'd5);
        chk("wb_addr", 64'(wb_addr_seen), 64'h0004);
        chk("wb_word1", 64'(wb_data_seen[31:16]), 64'h1234);
        chk("wb_word2", 64'(wb_data_seen[47:32]), 64'h5678);
        chk("wb_fill_n", 64'(fill_log.size()), 64'd1);
        chk("wb_fill_addr", 64'(fill_log[0]), 64'h1004);
        chk("wb_rd_data", 64'(rd_data), 64'hCAFE);
        chk("wb_d_cnt", 64'(d_miss_cnt), 64'd2);
        chk("never_both", 64'(both_seen), 64'd0);

        // Write miss allocates, then the store lands as a hit
        re = 1'b0; we = 1'b1; d_addr = 16'h0030; wrt_data = 16'hAAAA; #1;
        service(1, 64'd0, st);
        chk("wa_stalls", 64'(st), 64'd2);
        @(negedge clk); we = 1'b0; re = 1'b1; #1;
        chk("wa_rd_data", 64'(rd_data), 64'hAAAA);
        chk("wa_d_cnt", 64'(d_miss_cnt), 64'd3);

        // Simultaneous I and D miss: D is served first
        do_reset();
        fill_log.delete();
        i_fetch = 1'b1; i_addr = 16'h0100; re = 1'b1; d_addr = 16'h0200; #1;
        chk("arb_stall_c0", 64'(stall), 64'd1);
        service(1, {16'h0, 16'h0, 16'h0, 16'hD0D0}, st);
        chk("arb_stalls", 64'(st), 64'd4);
        chk("arb_fill_n", 64'(fill_log.size()), 64'd2);
        chk("arb_first_d", 64'(fill_log[0]), 64'h0080);
        chk("arb_then_i", 64'(fill_log[1]), 64'h0040);
        chk("arb_i_cnt", 64'(i_miss_cnt), 64'd1);
        chk("arb_d_cnt", 64'(d_miss_cnt), 64'd1);
        chk("arb_instr", 64'(instr), 64'hD0D0);
        chk("arb_rd_data", 64'(rd_data), 64'hD0D0);

        // Stray m_rdy in IDLE is ignored
        i_fetch = 1'b0; re = 1'b0; m_rdy = 1'b1;
        @(negedge clk); m_rdy = 1'b0; #1;
        chk("stray_rdy_re", 64'(m_re | m_we), 64'd0);

        // Reset during FILL_D with m_rdy in the same cycle
        do_reset();
        re = 1'b1; d_addr = 16'h0010; #1;
        chk("abort_stall_c0", 64'(stall), 64'd1);
        @(negedge clk); #1;
        chk("abort_in_fill", 64'(m_re), 64'd1);
        m_rdy = 1'b1; m_rdata = {16'h3333, 16'h2222, 16'h1111, 16'hBEEF}; rst = 1'b1;
        @(negedge clk); m_rdy = 1'b0; rst = 1'b0; #1;
        chk("abort_m_re", 64'(m_re | m_we), 64'd0);
        chk("abort_m_addr", 64'(m_addr), 64'd0);
        chk("abort_remiss", 64'(stall), 64'd1);
        chk("abort_d_cnt", 64'(d_miss_cnt), 64'd0);
        service(1, {16'h3333, 16'h2222, 16'h1111, 16'hBEEF}, st);
        chk("abort_refill_stalls", 64'(st), 64'd2);
        chk("abort_refill_data", 64'(rd_data), 64'hBEEF);
        chk("abort_refill_cnt", 64'(d_miss_cnt), 64'd1);

        // Counter saturation
        @(negedge clk);
        force dut.d_miss_cnt = 16'hFFFE;
        #1;
        release dut.d_miss_cnt;
        chk("sat_preset", 64'(d_miss_cnt), 64'hFFFE);
        d_addr = 16'h0800; #1;
        service(1, 64'd0, st);
        chk("sat_first", 64'(d_miss_cnt), 64'hFFFF);
        d_addr = 16'h0804; #1;
        service(1, 64'd0, st);
        d_addr = 16'h0808; #1;
        service(1, 64'd0, st);
        chk("sat_no_wrap", 64'(d_miss_cnt), 64'hFFFF);
        chk("sat_i_cnt", 64'(i_miss_cnt), 64'd0);

        re = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
